// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: three pause-stalled master ports plus the shared SRAM bus
interface sram_port_arbiter_if;
  logic        req_0, req_1, req_2;
  logic        wren_0, wren_1, wren_2;
  logic [17:0] address_0, address_1, address_2;
  logic [31:0] data_write_0, data_write_1, data_write_2;
  logic        pause_0, pause_1, pause_2;
  logic [31:0] data_read;
  logic        read_valid_0, read_valid_1, read_valid_2;
  logic        mem_wren;
  logic [17:0] mem_address;
  logic [31:0] mem_data_write;
  logic [31:0] mem_data_read;
  modport slave (
    input  req_0, req_1, req_2, wren_0, wren_1, wren_2,
    input  address_0, address_1, address_2, data_write_0, data_write_1, data_write_2,
    input  mem_data_read,
    output pause_0, pause_1, pause_2, data_read, read_valid_0, read_valid_1, read_valid_2,
    output mem_wren, mem_address, mem_data_write
  );
  modport master (
    output req_0, req_1, req_2, wren_0, wren_1, wren_2,
    output address_0, address_1, address_2, data_write_0, data_write_1, data_write_2,
    output mem_data_read,
    input  pause_0, pause_1, pause_2, data_read, read_valid_0, read_valid_1, read_valid_2,
    input  mem_wren, mem_address, mem_data_write
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin, burst-bounded sharing of one SRAM port among three pause-stalled masters
module sram_port_arbiter #(
  parameter int HOLD_CYCLES  = 16,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, ptr_q, ptr_d, issue_port_q, issue_port_d;
  logic [7:0] burst_q, burst_d;
  logic [2:0] pause_q, pause_d, read_valid_q, read_valid_d, req, wren, others;
  logic issue_valid_q, issue_valid_d, mem_wren_q, mem_wren_d, iss_wren;
  logic [17:0] mem_address_q, mem_address_d, iss_address;
  logic [31:0] mem_data_write_q, mem_data_write_d, iss_data, data_read_q, data_read_d;
  logic [READ_LATENCY:0][2:0] tag_q, tag_d;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    return r[p] ? p : r[nxt(p)] ? nxt(p) : nxt(nxt(p));
  endfunction

  assign req = {bus.req_2, bus.req_1, bus.req_0};
  assign wren = {bus.wren_2, bus.wren_1, bus.wren_0};
  assign others = req & ~(3'b001 << owner_q);
  assign iss_wren = wren[issue_port_q];
  assign iss_address = issue_port_q == 2'd0 ? bus.address_0 : issue_port_q == 2'd1 ? bus.address_1 : bus.address_2;
  assign iss_data = issue_port_q == 2'd0 ? bus.data_write_0 : issue_port_q == 2'd1 ? bus.data_write_1 : bus.data_write_2;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    burst_d = burst_q;
    if (state_q == GRANT) begin
      if (!req[owner_q] || (burst_q == 8'(HOLD_CYCLES) && |others)) begin
        state_d = TURN;
        ptr_d = nxt(owner_q);
      end else
        burst_d = burst_q == 8'(HOLD_CYCLES) ? 8'd1 : burst_q + 8'd1;
    end else if (|req) begin
      state_d = GRANT;
      owner_d = pick(req, ptr_q);
      burst_d = 8'd1;
    end else
      state_d = IDLE;
    pause_d = state_d == GRANT ? ~(3'b001 << owner_d) : 3'b111;
    // an owner whose req is already low issued nothing at this edge
    issue_valid_d = state_q == GRANT && req[owner_q];
    issue_port_d = owner_q;
    mem_wren_d = issue_valid_q && iss_wren;
    mem_address_d = issue_valid_q ? iss_address : mem_address_q;
    mem_data_write_d = issue_valid_q ? iss_data : mem_data_write_q;
    tag_d = {tag_q[READ_LATENCY-1:0], issue_valid_q && !iss_wren, issue_port_q};
    data_read_d = tag_q[READ_LATENCY][2] ? bus.mem_data_read : data_read_q;
    read_valid_d = tag_q[READ_LATENCY][2] ? 3'b001 << tag_q[READ_LATENCY][1:0] : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      burst_q <= '0;
      pause_q <= 3'b111;
      issue_valid_q <= 1'b0;
      issue_port_q <= '0;
      mem_wren_q <= 1'b0;
      mem_address_q <= '0;
      mem_data_write_q <= '0;
      tag_q <= '0;
      data_read_q <= '0;
      read_valid_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      burst_q <= burst_d;
      pause_q <= pause_d;
      issue_valid_q <= issue_valid_d;
      issue_port_q <= issue_port_d;
      mem_wren_q <= mem_wren_d;
      mem_address_q <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
      tag_q <= tag_d;
      data_read_q <= data_read_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign {bus.pause_2, bus.pause_1, bus.pause_0} = pause_q;
  assign {bus.read_valid_2, bus.read_valid_1, bus.read_valid_0} = read_valid_q;
  assign bus.data_read = data_read_q;
  assign bus.mem_wren = mem_wren_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_write = mem_data_write_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vectors against hand-computed grant, bus and read-return timelines
module tb_sram_port_arbiter;
  logic clk, reset;
  int vectors = 0, miscompares = 0;
  sram_port_arbiter_if bus();
  sram_port_arbiter #(.HOLD_CYCLES(4), .READ_LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [2:0] rq, wr, wr_o, pzs, rqs;
  int left [3];
  logic [17:0] nxt [3];
  logic [17:0] ad_o [3];
  logic [31:0] dat [3];
  logic [31:0] dt_o [3];
  logic [17:0] a1, a2, ma;
  logic [18:0] t2_mem [22];
  logic [2:0] t2_pz [22];
  logic [18:0] t4_mem [8];
  logic [2:0] t4_pz [8];
  logic [2:0] t5_pz [16];

  assign bus.req_0 = rq[0];
  assign bus.req_1 = rq[1];
  assign bus.req_2 = rq[2];
  assign bus.wren_0 = wr_o[0];
  assign bus.wren_1 = wr_o[1];
  assign bus.wren_2 = wr_o[2];
  assign bus.address_0 = ad_o[0];
  assign bus.address_1 = ad_o[1];
  assign bus.address_2 = ad_o[2];
  assign bus.data_write_0 = dt_o[0];
  assign bus.data_write_1 = dt_o[1];
  assign bus.data_write_2 = dt_o[2];
  assign bus.mem_data_read = a2 == 18'h00010 ? 32'hDEADBEEF : {14'h0, a2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] pz();
    return {bus.pause_2, bus.pause_1, bus.pause_0};
  endfunction
  function automatic logic [2:0] rv();
    return {bus.read_valid_2, bus.read_valid_1, bus.read_valid_0};
  endfunction
  function automatic logic [18:0] mwa();
    return {bus.mem_wren, bus.mem_address};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq = '0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic start(input int p, input int n, input logic [17:0] a, input logic w, input logic [31:0] d);
    left[p] = n;
    nxt[p] = a;
    wr[p] = w;
    dat[p] = d;
    rq[p] = 1'b1;
  endtask

  // masters advance one access per edge while unpaused; SRAM returns data two cycles after the address
  initial begin
    a1 = '0;
    a2 = '0;
    wr_o = '0;
    for (int p = 0; p < 3; p++) begin
      ad_o[p] = '0;
      dt_o[p] = '0;
    end
    forever begin
      @(posedge clk);
      pzs = pz();
      rqs = rq;
      ma = bus.mem_address;
      #1;
      a2 = a1;
      a1 = ma;
      for (int p = 0; p < 3; p++)
        if (rqs[p] && !pzs[p]) begin
          ad_o[p] = nxt[p];
          wr_o[p] = wr[p];
          dt_o[p] = dat[p];
          nxt[p] = nxt[p] + 18'd1;
          left[p] = left[p] - 1;
          if (left[p] == 0) rq[p] = 1'b0;
        end
    end
  end

  initial begin
    t2_mem = '{19'h00000, 19'h00000, 19'h40100, 19'h40101, 19'h40102, 19'h40103, 19'h00103, 19'h40200,
               19'h40201, 19'h40202, 19'h40203, 19'h00203, 19'h40104, 19'h40105, 19'h40106, 19'h40107,
               19'h00107, 19'h40204, 19'h40205, 19'h40206, 19'h40207, 19'h00207};
    t2_pz = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b110,
              3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111};
    t4_mem = '{19'h00000, 19'h00000, 19'h40300, 19'h40301, 19'h00301, 19'h00301, 19'h40400, 19'h00400};
    t4_pz = '{3'b101, 3'b101, 3'b101, 3'b111, 3'b011, 3'b011, 3'b111, 3'b111};
    t5_pz = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b011,
              3'b011, 3'b011, 3'b011, 3'b111, 3'b110};
    rq = '0;
    wr = '0;
    do_reset();
    chk("rst_pause", 64'(pz()), 64'h7);
    chk("rst_read_valid", 64'(rv()), 64'h0);
    chk("rst_mem", 64'(mwa()), 64'h0);
    chk("rst_mem_data", 64'(bus.mem_data_write), 64'h0);
    chk("rst_data_read", 64'(bus.data_read), 64'h0);

    start(0, 40, 18'h0, 1'b1, 32'h77553311);
    cyc();
    chk("t1_grant_pause", 64'(pz()), 64'h6);
    cyc();
    chk("t1_first_idle_bus", 64'(mwa()), 64'h0);
    for (int k = 0; k < 40; k++) begin
      cyc();
      chk($sformatf("t1_write[%0d]", k), {13'h0, bus.mem_wren, bus.mem_address, bus.mem_data_write},
          {13'h0, 1'b1, 18'(k), 32'h77553311});
      if (k < 39) chk($sformatf("t1_pause[%0d]", k), 64'(pz()), 64'h6);
    end
    cyc();
    chk("t1_end_bus", 64'(mwa()), 64'd39);
    chk("t1_end_pause", 64'(pz()), 64'h7);

    do_reset();
    start(0, 8, 18'h100, 1'b1, 32'h11110000);
    start(1, 8, 18'h200, 1'b1, 32'h22220000);
    for (int e = 0; e < 22; e++) begin
      cyc();
      chk($sformatf("t2_mem[%0d]", e), 64'(mwa()), 64'(t2_mem[e]));
      chk($sformatf("t2_pause[%0d]", e), 64'(pz()), 64'(t2_pz[e]));
    end

    do_reset();
    start(2, 1, 18'h00010, 1'b0, 32'h0);
    repeat (3) cyc();
    chk("t3_read_addr", 64'(mwa()), 64'h00010);
    cyc();
    chk("t3_rv_e3", 64'(rv()), 64'h0);
    cyc();
    chk("t3_rv_e4", 64'(rv()), 64'h0);
    cyc();
    chk("t3_rv_e5", 64'(rv()), 64'h4);
    chk("t3_data", 64'(bus.data_read), 64'hDEADBEEF);
    cyc();
    chk("t3_rv_e6", 64'(rv()), 64'h0);
    chk("t3_data_hold", 64'(bus.data_read), 64'hDEADBEEF);

    do_reset();
    start(1, 2, 18'h300, 1'b1, 32'h33330000);
    start(2, 1, 18'h400, 1'b1, 32'h44440000);
    for (int e = 0; e < 8; e++) begin
      cyc();
      chk($sformatf("t4_mem[%0d]", e), 64'(mwa()), 64'(t4_mem[e]));
      chk($sformatf("t4_pause[%0d]", e), 64'(pz()), 64'(t4_pz[e]));
    end

    do_reset();
    start(0, 5, 18'h500, 1'b1, 32'h0);
    start(1, 4, 18'h600, 1'b1, 32'h0);
    start(2, 4, 18'h700, 1'b1, 32'h0);
    for (int e = 0; e < 16; e++) begin
      cyc();
      chk($sformatf("t5_pause[%0d]", e), 64'(pz()), 64'(t5_pz[e]));
    end

    do_reset();
    start(0, 20, 18'h20, 1'b0, 32'h0);
    repeat (6) cyc();
    chk("t6_rv_before", 64'(rv()), 64'h1);
    chk("t6_data_before", 64'(bus.data_read), 64'h20);
    reset = 1'b1;
    rq = '0;
    cyc();
    chk("t6_rst_wren", 64'(bus.mem_wren), 64'h0);
    chk("t6_rst_pause", 64'(pz()), 64'h7);
    chk("t6_rst_rv", 64'(rv()), 64'h0);
    reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      cyc();
      chk($sformatf("t6_post_rv[%0d]", e), 64'(rv()), 64'h0);
      chk($sformatf("t6_post_wren[%0d]", e), 64'(bus.mem_wren), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
